fft_frame_ctrl: RTL

Frame sequencer for the 16-point CORDIC FFT core (fft1).
- Accepts a serial complex sample stream with a valid/ready handshake and assembles 16-sample frames.
- Presents each complete frame to the core's parallel inputs and holds it for the core's fixed latency.
- Captures the 16 parallel results and streams them back out serially with valid/ready.
- Sits between the sample source and the core, so upstream logic never drives the 32 wide core input ports directly.

---
 rtl/fft_frame_ctrl_if.sv | 31 +++
 rtl/fft_frame_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl_if.sv
// Streaming handshake bundle for fft_frame_ctrl.
//   in_valid/in_ready/in_re/in_im        : serial complex sample input
//   out_valid/out_ready/out_re/out_im    : serial complex bin output
//   out_idx/out_last                     : bin index 0..15, high with bin 15
// The master modport is the stream endpoint (source and sink side); the slave modport is the
// controller.
interface fft_frame_ctrl_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 17
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_re;
  logic [IN_W-1:0]  in_im;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_re;
  logic [OUT_W-1:0] out_im;
  logic [3:0]       out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 16-point CORDIC FFT core.
// Collects 16 serial samples into the core's parallel input ports, holds them for FFT_LAT
// cycles, captures the 16 parallel bins and streams them back out serially.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   bus            : sample/bin stream handshakes (fft_frame_ctrl_if.slave)
//   fft_x, fft_y   : packed core inputs, sample k at [IN_W*k +: IN_W]
//   fft_xo, fft_yo : packed core outputs, bin k at [OUT_W*k +: OUT_W]
//   busy           : frame held in the core or being unloaded
//   frame_cnt      : completed frames, wraps at 256
module fft_frame_ctrl #(
  parameter int unsigned N       = 16,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 17,
  parameter int unsigned FFT_LAT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  fft_frame_ctrl_if.slave      bus,
  output logic [N*IN_W-1:0]    fft_x,
  output logic [N*IN_W-1:0]    fft_y,
  input  logic [N*OUT_W-1:0]   fft_xo,
  input  logic [N*OUT_W-1:0]   fft_yo,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam logic [7:0] LatLast = 8'(FFT_LAT - 1);

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  state_e           state_q, state_d;
  logic [3:0]       wr_cnt;
  logic [3:0]       rd_cnt;
  logic [7:0]       lat_cnt;
  logic [OUT_W-1:0] cap_re [16];
  logic [OUT_W-1:0] cap_im [16];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StLoad;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:    if (bus.in_valid && (wr_cnt == 4'd15)) state_d = StCompute;
      StCompute: if (lat_cnt == LatLast) state_d = StUnload;
      StUnload:  if (bus.out_ready && (rd_cnt == 4'd15)) state_d = StLoad;
      default:   state_d = StLoad;
    endcase
  end

  // in_ready is gated by reset so it only rises once reset is released.
  assign bus.in_ready  = (state_q == StLoad) && !reset;
  assign bus.out_valid = (state_q == StUnload);
  assign bus.out_last  = (state_q == StUnload) && (rd_cnt == 4'd15);
  assign busy          = (state_q != StLoad);

  // Datapath. out_re/out_im/out_idx are registered copies of capture slot rd_cnt so they
  // keep showing bin 15 after the frame drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fft_x       <= '0;
      fft_y       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      lat_cnt     <= '0;
      frame_cnt   <= '0;
      bus.out_re  <= '0;
      bus.out_im  <= '0;
      bus.out_idx <= '0;
      for (int k = 0; k < 16; k++) begin
        cap_re[k] <= '0;
        cap_im[k] <= '0;
      end
    end else begin
      case (state_q)
        StLoad: begin
          if (bus.in_valid) begin
            for (int k = 0; k < 16; k++) begin
              if (wr_cnt == 4'(k)) begin
                fft_x[k*IN_W +: IN_W] <= bus.in_re;
                fft_y[k*IN_W +: IN_W] <= bus.in_im;
              end
            end
            wr_cnt <= wr_cnt + 4'd1;  // wraps to 0 on slot 15
            if (wr_cnt == 4'd15) lat_cnt <= '0;
          end
        end
        StCompute: begin
          lat_cnt <= lat_cnt + 8'd1;
          if (lat_cnt == LatLast) begin
            for (int k = 0; k < 16; k++) begin
              cap_re[k] <= fft_xo[k*OUT_W +: OUT_W];
              cap_im[k] <= fft_yo[k*OUT_W +: OUT_W];
            end
            rd_cnt      <= '0;
            bus.out_re  <= fft_xo[0 +: OUT_W];
            bus.out_im  <= fft_yo[0 +: OUT_W];
            bus.out_idx <= '0;
          end
        end
        StUnload: begin
          if (bus.out_ready) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_cnt == 4'd15) begin
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              bus.out_re  <= cap_re[rd_cnt + 4'd1];
              bus.out_im  <= cap_im[rd_cnt + 4'd1];
              bus.out_idx <= rd_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
